// File: rtl/spi_reg_bridge.sv
`timescale 1ns/1ps
// spi_reg_bridge: SPI mode-0 slave that turns framed SPI traffic into
// register-bus reads and writes.
//
// A frame is one command byte followed by one or more data words, all MSB first:
//   cmd[7] = 1 write / 0 read, cmd[6] = burst, cmd[ADDR_W-1:0] = start address.
//
// Ports:
//   clk, rst_n            system clock, async active-low reset
//   spi_cs_n/clk/mosi     raw SPI pins, synchronized internally
//   spi_miso, spi_miso_oe serial read data and its pad enable (read data phase only)
//   reg_addr, reg_wdata   register address and write data (both hold between frames)
//   reg_wr, reg_rd        one-clk strobes
//   reg_rdata             read data, valid the clk after reg_rd
//   frame_err             one-clk pulse when cs_n rises mid-command or mid-word
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | cs_n high, or cs_n low without a fresh falling edge
// S_CMD   | shifting in the command byte
// S_WDATA | shifting in write words
// S_RDATA | shifting out read words, MISO driven
module spi_reg_bridge #(
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_cs_n,
  input  logic              spi_clk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_wr,
  output logic              reg_rd,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              frame_err
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(7);
  localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_WDATA, S_RDATA} state_t;

  // cs_n synchronizer resets low so a cs_n already low at reset release
  // never looks like a fresh falling edge.
  logic [SYNC_STAGES-1:0] cs_sync_q, sck_sync_q, mosi_sync_q;
  logic                   cs_prev_q, sck_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync_q   <= '0;
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      cs_prev_q   <= 1'b0;
      sck_prev_q  <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_clk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
      sck_prev_q  <= sck_sync_q[SYNC_STAGES-1];
    end
  end

  logic cs_s, sck_s, mosi_s;
  logic cs_fall, cs_rise, sck_rise, sck_fall;

  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign cs_fall  = cs_prev_q & ~cs_s;
  assign cs_rise  = ~cs_prev_q & cs_s;
  assign sck_rise = ~sck_prev_q & sck_s;
  assign sck_fall = sck_prev_q & ~sck_s;

  state_t            state_q;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic [DATA_W-2:0] shift_in_q;   // the last bit of a word comes straight from mosi_s
  logic [DATA_W-1:0] shift_out_q;
  logic              burst_q;
  logic              skip_fall_q;  // swallow the falling edge ahead of a word's first bit
  logic              rd_cap_q;     // reg_rdata is valid this clk
  logic              inc_q;        // bump address once the reg_wr strobe has been seen
  logic [ADDR_W-1:0] reg_addr_q;
  logic [DATA_W-1:0] reg_wdata_q;
  logic              reg_wr_q, reg_rd_q, frame_err_q, miso_oe_q;
  logic              word_last;

  assign word_last = (state_q == S_CMD) ? (bit_cnt_q == CMD_LAST) : (bit_cnt_q == WORD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      shift_in_q  <= '0;
      shift_out_q <= '0;
      burst_q     <= 1'b0;
      skip_fall_q <= 1'b0;
      rd_cap_q    <= 1'b0;
      inc_q       <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_wr_q    <= 1'b0;
      reg_rd_q    <= 1'b0;
      frame_err_q <= 1'b0;
      miso_oe_q   <= 1'b0;
    end else begin
      reg_wr_q    <= 1'b0;
      reg_rd_q    <= 1'b0;
      frame_err_q <= 1'b0;
      inc_q       <= 1'b0;
      rd_cap_q    <= reg_rd_q;
      if (inc_q) reg_addr_q <= reg_addr_q + ADDR_W'(1);

      case (state_q)
        S_IDLE: begin
          if (cs_fall) begin
            state_q    <= S_CMD;
            bit_cnt_q  <= '0;
            shift_in_q <= '0;
          end
        end
        S_CMD: begin
          if (sck_rise) begin
            shift_in_q <= {shift_in_q[DATA_W-3:0], mosi_s};
            if (word_last) begin
              bit_cnt_q  <= '0;
              reg_addr_q <= ADDR_W'({shift_in_q[6:0], mosi_s});
              burst_q    <= shift_in_q[5];
              if (shift_in_q[6]) begin
                state_q <= S_WDATA;
              end else begin
                state_q     <= S_RDATA;
                reg_rd_q    <= 1'b1;
                miso_oe_q   <= 1'b1;
                skip_fall_q <= 1'b1;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end
          end
        end
        S_WDATA: begin
          if (sck_rise) begin
            shift_in_q <= {shift_in_q[DATA_W-3:0], mosi_s};
            if (word_last) begin
              bit_cnt_q   <= '0;
              reg_wdata_q <= {shift_in_q, mosi_s};
              reg_wr_q    <= 1'b1;
              inc_q       <= burst_q;
            end else begin
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end
          end
        end
        S_RDATA: begin
          if (sck_rise) begin
            if (word_last) begin
              bit_cnt_q   <= '0;
              skip_fall_q <= 1'b1;
              reg_rd_q    <= 1'b1;
              if (burst_q) reg_addr_q <= reg_addr_q + ADDR_W'(1);
            end else begin
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end
          end
          if (sck_fall) begin
            if (skip_fall_q) skip_fall_q <= 1'b0;
            else             shift_out_q <= {shift_out_q[DATA_W-2:0], 1'b0};
          end
          if (rd_cap_q) shift_out_q <= reg_rdata;
        end
        default: state_q <= S_IDLE;
      endcase

      // A last-bit rising edge in the same clk as cs_n rising still completes the word.
      if (state_q != S_IDLE && cs_rise) begin
        state_q     <= S_IDLE;
        miso_oe_q   <= 1'b0;
        shift_out_q <= '0;
        skip_fall_q <= 1'b0;
        bit_cnt_q   <= '0;
        frame_err_q <= (bit_cnt_q != '0) && !(sck_rise && word_last);
      end
    end
  end

  assign spi_miso    = shift_out_q[DATA_W-1];
  assign spi_miso_oe = miso_oe_q;
  assign reg_addr    = reg_addr_q;
  assign reg_wdata   = reg_wdata_q;
  assign reg_wr      = reg_wr_q;
  assign reg_rd      = reg_rd_q;
  assign frame_err   = frame_err_q;

endmodule
